// File: rtl/game_scoreboard.sv
// game_scoreboard: accumulates per-round scores for two players over ROUNDS
// rounds, then judges the match and holds the winner until a new match.
`default_nettype none

module game_scoreboard #(
    parameter int ROUNDS  = 3,
    parameter int TOTAL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               score_valid,
    input  logic [3:0]         score1,
    input  logic [3:0]         score2,
    input  logic               new_match,
    output logic               score_ready,
    output logic [TOTAL_W-1:0] total1,
    output logic [TOTAL_W-1:0] total2,
    output logic [3:0]         round_cnt,
    output logic [1:0]         winner,
    output logic               match_done
);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_JUDGE   = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [3:0]         ROUNDS_C = 4'(ROUNDS);
    localparam logic [TOTAL_W-1:0] MAX_C    = '1;

    state_t             state_q, state_d;
    logic [TOTAL_W-1:0] total1_q, total1_d;
    logic [TOTAL_W-1:0] total2_q, total2_d;
    logic [3:0]         round_q, round_d;
    logic [1:0]         winner_q, winner_d;
    logic               accept;

    // One extra carry bit detects overflow so the sum clamps instead of wrapping.
    function automatic logic [TOTAL_W-1:0] sat_add(input logic [TOTAL_W-1:0] a,
                                                  input logic [3:0]         s);
        logic [TOTAL_W:0] sum;
        sum = {1'b0, a} + {{(TOTAL_W-3){1'b0}}, s};
        return sum[TOTAL_W] ? MAX_C : sum[TOTAL_W-1:0];
    endfunction

    assign score_ready = (state_q == ST_COLLECT) && !new_match && !rst;
    assign accept      = score_valid && score_ready;

    always_comb begin
        state_d  = state_q;
        total1_d = total1_q;
        total2_d = total2_q;
        round_d  = round_q;
        winner_d = winner_q;
        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    total1_d = sat_add(total1_q, score1);
                    total2_d = sat_add(total2_q, score2);
                    round_d  = round_q + 4'd1;
                    if (round_q + 4'd1 == ROUNDS_C) begin
                        state_d = ST_JUDGE;
                    end
                end
            end
            ST_JUDGE: begin
                if (total1_q > total2_q) begin
                    winner_d = 2'b01;
                end else if (total2_q > total1_q) begin
                    winner_d = 2'b10;
                end else begin
                    winner_d = 2'b11;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
        // A new-match request overrides everything, including an in-flight judgement.
        if (new_match) begin
            state_d  = ST_COLLECT;
            total1_d = '0;
            total2_d = '0;
            round_d  = 4'd0;
            winner_d = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_COLLECT;
            total1_q <= '0;
            total2_q <= '0;
            round_q  <= 4'd0;
            winner_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            total1_q <= total1_d;
            total2_q <= total2_d;
            round_q  <= round_d;
            winner_q <= winner_d;
        end
    end

    assign total1     = total1_q;
    assign total2     = total2_q;
    assign round_cnt  = round_q;
    assign winner     = winner_q;
    assign match_done = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_game_scoreboard.sv
// tb_game_scoreboard: directed stimulus with a queue-based scoreboard for
// the default configuration and a narrow saturating configuration.
`default_nettype none

module tb_game_scoreboard;

    typedef struct {
        string name;
        int    t1;
        int    t2;
        int    rc;
        int    win;
        int    done;
        int    rdy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       score_valid = 1'b0;
    logic [3:0] score1 = 4'd0;
    logic [3:0] score2 = 4'd0;
    logic       new_match = 1'b0;
    logic       score_ready;
    logic [7:0] total1, total2;
    logic [3:0] round_cnt;
    logic [1:0] winner;
    logic       match_done;

    logic       sv2 = 1'b0;
    logic [3:0] a2 = 4'd0;
    logic [3:0] b2 = 4'd0;
    logic       nm2 = 1'b0;
    logic       rdy2;
    logic [4:0] s_t1, s_t2;
    logic [3:0] s_rc;
    logic [1:0] s_win;
    logic       s_done;

    exp_t q_main[$];
    exp_t q_sat[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic chk_req = 1'b0;
    logic acc_seen = 1'b0, nm_seen = 1'b0, done_prev = 1'b0;
    logic acc2_seen = 1'b0, done2_prev = 1'b0;

    game_scoreboard #(.ROUNDS(3), .TOTAL_W(8)) u_dut (
        .clk(clk), .rst(rst), .score_valid(score_valid), .score1(score1),
        .score2(score2), .new_match(new_match), .score_ready(score_ready),
        .total1(total1), .total2(total2), .round_cnt(round_cnt),
        .winner(winner), .match_done(match_done)
    );

    game_scoreboard #(.ROUNDS(5), .TOTAL_W(5)) u_sat (
        .clk(clk), .rst(rst), .score_valid(sv2), .score1(a2),
        .score2(b2), .new_match(nm2), .score_ready(rdy2),
        .total1(s_t1), .total2(s_t2), .round_cnt(s_rc),
        .winner(s_win), .match_done(s_done)
    );

    always #5 clk = ~clk;

    function automatic void cmp(exp_t e, int t1, int t2, int rc, int win, int done, int rdy);
        vectors++;
        if (t1 != e.t1 || t2 != e.t2 || rc != e.rc || win != e.win ||
            done != e.done || rdy != e.rdy) begin
            miscompares++;
            $display("FAIL %s: got t1=%0d t2=%0d rc=%0d win=%0d done=%0d rdy=%0d, expected t1=%0d t2=%0d rc=%0d win=%0d done=%0d rdy=%0d",
                     e.name, t1, t2, rc, win, done, rdy,
                     e.t1, e.t2, e.rc, e.win, e.done, e.rdy);
        end
    endfunction

    always @(posedge clk) begin
        acc_seen  <= score_valid && score_ready;
        nm_seen   <= new_match;
        acc2_seen <= sv2 && rdy2;
    end

    // Main monitor: an accept, a new-match, a rising match_done or an explicit request produces one check.
    always @(negedge clk or posedge chk_req) begin
        if (chk_req || acc_seen || nm_seen || (match_done && !done_prev)) begin
            if (q_main.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL main_unexpected_output: got t1=%0d rc=%0d done=%0d, expected no output",
                         total1, round_cnt, match_done);
            end else begin
                cmp(q_main.pop_front(), int'(total1), int'(total2), int'(round_cnt),
                    int'(winner), int'(match_done), int'(score_ready));
            end
        end
        if (!chk_req) done_prev = match_done;
    end

    always @(negedge clk) begin
        if (acc2_seen || (s_done && !done2_prev)) begin
            if (q_sat.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sat_unexpected_output: got t1=%0d rc=%0d done=%0d, expected no output",
                         s_t1, s_rc, s_done);
            end else begin
                cmp(q_sat.pop_front(), int'(s_t1), int'(s_t2), int'(s_rc),
                    int'(s_win), int'(s_done), int'(rdy2));
            end
        end
        done2_prev = s_done;
    end

    task automatic push(input string n, input int t1, input int t2, input int rc,
                        input int win, input int done, input int rdy);
        exp_t e;
        e = '{name: n, t1: t1, t2: t2, rc: rc, win: win, done: done, rdy: rdy};
        q_main.push_back(e);
    endtask

    task automatic chk(input string n, input int t1, input int t2, input int rc,
                       input int win, input int done, input int rdy);
        push(n, t1, t2, rc, win, done, rdy);
        #1 chk_req = 1'b1;
        #1 chk_req = 1'b0;
    endtask

    task automatic round(input string n, input int s1, input int s2, input int t1,
                         input int t2, input int rc, input int rdy);
        push(n, t1, t2, rc, 0, 0, rdy);
        @(negedge clk);
        #1;
        score_valid = 1'b1;
        score1 = 4'(s1);
        score2 = 4'(s2);
        @(posedge clk);
        #1 score_valid = 1'b0;
    endtask

    task automatic newm(input string n, input logic sv);
        push(n, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        #1;
        new_match = 1'b1;
        score_valid = sv;
        score1 = 4'd5;
        score2 = 4'd5;
        @(posedge clk);
        #1;
        new_match = 1'b0;
        score_valid = 1'b0;
    endtask

    task automatic round2(input string n, input int s1, input int s2, input int t1,
                          input int t2, input int rc, input int rdy);
        exp_t e;
        e = '{name: n, t1: t1, t2: t2, rc: rc, win: 0, done: 0, rdy: rdy};
        q_sat.push_back(e);
        @(negedge clk);
        #1;
        sv2 = 1'b1;
        a2 = 4'(s1);
        b2 = 4'(s2);
        @(posedge clk);
        #1 sv2 = 1'b0;
    endtask

    initial begin
        exp_t e;
        #2 chk("in_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #2 chk("after_reset", 0, 0, 0, 0, 0, 1);

        round("m1_r1", 2, 6, 2, 6, 1, 1);
        round("m1_r2", 4, 4, 6, 10, 2, 1);
        round("m1_r3", 8, 0, 14, 10, 3, 0);
        push("m1_done", 14, 10, 3, 1, 1, 0);
        repeat (2) @(negedge clk);

        @(negedge clk);
        #1;
        score_valid = 1'b1;
        score1 = 4'd5;
        score2 = 4'd5;
        repeat (4) @(posedge clk);
        #1 score_valid = 1'b0;
        @(negedge clk);
        #2 chk("done_ignores_scores", 14, 10, 3, 1, 1, 0);

        newm("newmatch_with_score", 1'b1);

        round("tie_r1", 4, 4, 4, 4, 1, 1);
        round("tie_r2", 4, 4, 8, 8, 2, 1);
        round("tie_r3", 4, 4, 12, 12, 3, 0);
        push("tie_done", 12, 12, 3, 3, 1, 0);
        repeat (2) @(negedge clk);

        newm("restart_after_done", 1'b0);
        round("p2_r1", 0, 8, 0, 8, 1, 1);
        round("p2_r2", 2, 6, 2, 14, 2, 1);
        round("p2_r3", 4, 4, 6, 18, 3, 0);
        push("p2_done", 6, 18, 3, 2, 1, 0);
        repeat (2) @(negedge clk);

        newm("restart_2", 1'b0);
        round("ab_r1", 1, 1, 1, 1, 1, 1);
        round("ab_r2", 1, 1, 2, 2, 2, 1);
        round("ab_r3", 1, 1, 3, 3, 3, 0);
        newm("abort_in_judge", 1'b0);
        repeat (3) @(negedge clk);
        #2 chk("abort_no_winner", 0, 0, 0, 0, 0, 1);

        round("pre_reset", 3, 7, 3, 7, 1, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        chk("reset_pulse", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        round("post_reset", 1, 1, 1, 1, 1, 1);

        round2("sat_r1", 8, 0, 8, 0, 1, 1);
        round2("sat_r2", 8, 0, 16, 0, 2, 1);
        round2("sat_r3", 8, 0, 24, 0, 3, 1);
        round2("sat_r4", 8, 0, 31, 0, 4, 1);
        round2("sat_r5", 8, 0, 31, 0, 5, 0);
        e = '{name: "sat_done", t1: 31, t2: 0, rc: 5, win: 1, done: 1, rdy: 0};
        q_sat.push_back(e);
        repeat (4) @(negedge clk);

        if (q_main.size() != 0 || q_sat.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL missing_outputs: got %0d main and %0d sat expectations left, expected 0",
                     q_main.size(), q_sat.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
